// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serializes one byte per valid/ready handshake into a 10-bit UART frame
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       char_sent
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [7:0]      shift_q;
    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [3:0]      bit_q;
    logic            bit_end;

    // Bit boundary detection and wrapping per-bit cycle counter
    always_comb begin
        bit_end = tick_q == TW'(CLKS_PER_BIT - 1);
        tick_d  = bit_end ? '0 : tick_q + TW'(1);
    end

    // Frame FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            char_sent <= 1'b0;
        end else begin
            char_sent <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q   <= START;
                        shift_q   <= tx_data;
                        tick_q    <= '0;
                        bit_q     <= '0;
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START, DATA: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        bit_q <= bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            state_q   <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            state_q   <= DATA;
                            tx_serial <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                STOP: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        state_q   <= IDLE;
                        bit_q     <= '0;
                        char_sent <= 1'b1;
                        tx_ready  <= 1'b1;
                        tx_busy   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of the UART transmit framer at 16 clocks per bit
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       char_sent;

    int checks = 0;
    int errors = 0;

    logic ser [0:399];
    logic rdy [0:399];
    logic bsy [0:399];
    logic cs  [0:399];

    bit         rx_en = 1'b0;
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    int         cs_cnt = 0;

    uart_tx_frame #(.CLKS_PER_BIT(16)) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_serial(tx_serial),
        .tx_busy(tx_busy),
        .char_sent(char_sent)
    );

    always #5 clk = ~clk;

    // Reference receiver: detects the start bit, samples each bit mid-way, and requires a stop bit
    always @(negedge clk) begin
        if (rx_en) begin
            cs_cnt <= cs_cnt + ((char_sent === 1'b1) ? 1 : 0);
            if (!rx_act) begin
                if (tx_serial === 1'b0) begin
                    rx_act <= 1'b1;
                    rx_t   <= 1;
                end
            end else begin
                rx_t <= rx_t + 1;
                if (rx_t >= 24 && rx_t <= 136 && rx_t % 16 == 8)
                    rx_sh <= {tx_serial, rx_sh[7:1]};
                if (rx_t == 152) begin
                    rx_act <= 1'b0;
                    if (tx_serial === 1'b1) rx_q.push_back(rx_sh);
                end
            end
        end
    end

    // Expected line level at sample n (0 = first start-bit cycle) of a frame carrying b
    function automatic logic wave_bit(input logic [7:0] b, input int n);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[n / 16];
    endfunction

    function automatic int wave_bad(input int off, input logic [7:0] b);
        int bad = 0;
        for (int n = 0; n < 160; n++)
            if (ser[off + n] !== wave_bit(b, n)) bad++;
        return bad;
    endfunction

    function automatic int pulses(input int lo, input int hi);
        int c = 0;
        for (int n = lo; n < hi; n++)
            if (cs[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_pulse(input int lo, input int hi);
        for (int n = lo; n < hi; n++)
            if (cs[n] === 1'b1) return n;
        return -1;
    endfunction

    // Waits (bounded) for tx_ready, then presents b for one handshake edge
    task automatic handshake(input logic [7:0] b, input bit keep, output bit ok);
        int w = 0;
        ok = 1'b1;
        while (tx_ready !== 1'b1) begin
            if (w == 400) begin
                ok = 1'b0;
                break;
            end
            w++;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout tx_ready=%b required 1", tx_ready);
            return;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    // Records outputs at each negedge starting now; optional input events at given samples
    task automatic capture(input int len, input int chg_at, input logic [7:0] chg_val,
                           input int drop_at, input int rst_at);
        for (int n = 0; n < len; n++) begin
            ser[n] = tx_serial;
            rdy[n] = tx_ready;
            bsy[n] = tx_busy;
            cs[n]  = char_sent;
            if (n == chg_at) tx_data = chg_val;
            if (n == drop_at) tx_valid = 1'b0;
            if (n == rst_at) rst = 1'b0;
            if (rst_at >= 0 && n == rst_at + 1) rst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({tx_serial, tx_ready, tx_busy, char_sent} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_idle[%0d] ser/rdy/busy/sent=%b required 1100", i,
                         {tx_serial, tx_ready, tx_busy, char_sent});
            end
        end
    endtask

    task automatic test_release();
        int bad;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if ({tx_serial, tx_ready, tx_busy, char_sent} !== 4'b0010) begin
            errors++;
            $display("FAIL release_handshake ser/rdy/busy/sent=%b required 0010",
                     {tx_serial, tx_ready, tx_busy, char_sent});
        end
        capture(170, -1, 8'h00, -1, -1);
        bad = wave_bad(0, 8'h5A);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL release_wave bad_samples=%0d required 0", bad);
        end
    endtask

    task automatic test_single();
        bit ok;
        int bad, fp, np;
        handshake(8'hA5, 1'b0, ok);
        capture(170, -1, 8'h00, -1, -1);
        checks++;
        if ({rdy[0], bsy[0]} !== 2'b01) begin
            errors++;
            $display("FAIL single_busy_start rdy/busy=%b required 01", {rdy[0], bsy[0]});
        end
        bad = wave_bad(0, 8'hA5);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_wave bad_samples=%0d required 0", bad);
        end
        fp = first_pulse(0, 170);
        checks++;
        if (fp !== 160) begin
            errors++;
            $display("FAIL single_sent_time got=%0d required 160", fp);
        end
        np = pulses(0, 170);
        checks++;
        if (np !== 1) begin
            errors++;
            $display("FAIL single_sent_count got=%0d required 1", np);
        end
        checks++;
        if ({bsy[159], rdy[159], bsy[160], rdy[160]} !== 4'b1001) begin
            errors++;
            $display("FAIL single_frame_end busy/rdy@159,160=%b required 1001",
                     {bsy[159], rdy[159], bsy[160], rdy[160]});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad1, bad2, np, stray;
        handshake(8'h00, 1'b1, ok);
        capture(340, 1, 8'hFF, 161, -1);
        bad1 = wave_bad(0, 8'h00);
        bad2 = wave_bad(161, 8'hFF);
        checks++;
        if (bad1 !== 0 || bad2 !== 0) begin
            errors++;
            $display("FAIL b2b_wave bad_first=%0d bad_second=%0d required 0 0", bad1, bad2);
        end
        stray = 0;
        if (ser[160] !== 1'b1) stray++;
        for (int n = 321; n < 340; n++)
            if (ser[n] !== 1'b1) stray++;
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL b2b_idle_line stray_samples=%0d required 0", stray);
        end
        np = pulses(0, 340);
        checks++;
        if (np !== 2 || cs[160] !== 1'b1 || cs[321] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sent count=%0d at160=%b at321=%b required 2 1 1", np, cs[160], cs[321]);
        end
    endtask

    task automatic test_data_change();
        bit ok;
        int bad, np;
        handshake(8'h3C, 1'b0, ok);
        capture(170, 40, 8'hFF, -1, -1);
        bad = wave_bad(0, 8'h3C);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL data_change_wave bad_samples=%0d required 0", bad);
        end
        np = pulses(0, 170);
        checks++;
        if (np !== 1) begin
            errors++;
            $display("FAIL data_change_sent count=%0d required 1", np);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad, np, stray;
        handshake(8'h81, 1'b0, ok);
        capture(200, -1, 8'h00, -1, 70);
        checks++;
        if (ser[70] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pre ser@70=%b required 0", ser[70]);
        end
        checks++;
        if ({ser[71], rdy[71], bsy[71]} !== 3'b110) begin
            errors++;
            $display("FAIL reset_mid_abort ser/rdy/busy=%b required 110", {ser[71], rdy[71], bsy[71]});
        end
        stray = 0;
        for (int n = 71; n < 200; n++)
            if (ser[n] !== 1'b1) stray++;
        np = pulses(0, 200);
        checks++;
        if (np !== 0 || stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet sent=%0d stray=%0d required 0 0", np, stray);
        end
        handshake(8'h55, 1'b0, ok);
        capture(170, -1, 8'h00, -1, -1);
        bad = wave_bad(0, 8'h55);
        np = first_pulse(0, 170);
        checks++;
        if (bad !== 0 || np !== 160) begin
            errors++;
            $display("FAIL reset_mid_next bad_samples=%0d sent_at=%0d required 0 160", bad, np);
        end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [7:0] sent[$];
        logic [7:0] b;
        int nsent;
        rx_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            handshake(b, 1'b0, ok);
            if (!ok) break;
        end
        repeat (200) @(negedge clk);
        rx_en = 1'b0;
        nsent = sent.size();
        checks++;
        if (rx_q.size() !== nsent) begin
            errors++;
            $display("FAIL loop_rx_count got=%0d required %0d", rx_q.size(), nsent);
        end
        for (int i = 0; i < nsent && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== sent[i]) begin
                errors++;
                $display("FAIL loop_byte[%0d] got=%h required %h", i, rx_q[i], sent[i]);
            end
        end
        checks++;
        if (cs_cnt !== rx_q.size()) begin
            errors++;
            $display("FAIL loop_sent_vs_rx char_sent=%0d received=%0d", cs_cnt, rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_single();
        test_back_to_back();
        test_data_change();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
